// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment readback monitor: digit patterns (bit6..0 = a..g,
// active-high), FSM state encoding and the BCD-to-binary helper.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [6:0] FIELD_MAX = 7'd59;

  typedef enum logic [1:0] {IDLE, SCAN, COMBINE, REPORT} state_t;

  // tens*10 + ones using shifts only; two BCD digits never exceed 99
  function automatic logic [6:0] bcd_field(input logic [3:0] tens, input logic [3:0] ones);
    return ({3'b000, tens} << 3) + ({3'b000, tens} << 1) + {3'b000, ones};
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-high segment pattern into a BCD digit,
// flagging blank digits and patterns that are neither a digit nor blank.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       is_blank,
  output logic       is_err
);

  always_comb begin
    digit    = 4'd0;
    is_blank = 1'b0;
    is_err   = 1'b0;
    case (pattern)
      SEG_0:     digit = 4'd0;
      SEG_1:     digit = 4'd1;
      SEG_2:     digit = 4'd2;
      SEG_3:     digit = 4'd3;
      SEG_4:     digit = 4'd4;
      SEG_5:     digit = 4'd5;
      SEG_6:     digit = 4'd6;
      SEG_7:     digit = 4'd7;
      SEG_8:     digit = 4'd8;
      SEG_9:     digit = 4'd9;
      SEG_BLANK: is_blank = 1'b1;
      default:   is_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_decode_monitor.sv
// Snapshots the six HH:MM:SS segment buses on a sample strobe and decodes them back to time.
// Define SEG7_DECODE_SEQ_CHECK_EN to also flag frames that are not the same or next second.
module seg7_decode_monitor
  import seg7_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter int HOUR_MAX       = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample,
  input  logic [6:0] display_s1,
  input  logic [6:0] display_s2,
  input  logic [6:0] display_m1,
  input  logic [6:0] display_m2,
  input  logic [6:0] display_h1,
  input  logic [6:0] display_h2,
  output logic       busy,
  output logic       done,
  output logic [5:0] time_s,
  output logic [5:0] time_m,
  output logic [5:0] time_h,
  output logic [5:0] blank_mask,
  output logic [5:0] pat_err,
  output logic [2:0] range_err,
  output logic       seq_err
);

  state_t     state, next_state;
  logic [6:0] snap [6];
  logic [3:0] digit_work [6];
  logic [5:0] blank_work, pat_work;
  logic [2:0] idx;
  logic [6:0] field_s, field_m, field_h;
  logic [6:0] comb_s, comb_m, comb_h;
  logic [2:0] range_work;
  logic [6:0] sel_pat, dec_in;
  logic [3:0] dec_digit;
  logic       dec_blank, dec_err;
  logic       accept, frame_ok;

  // the done cycle is still IDLE, so it must be excluded explicitly
  assign accept   = (state == IDLE) && sample && !done;
  assign frame_ok = (pat_work == 6'd0) && (range_work == 3'd0);

  always_comb begin
    sel_pat = 7'd0;
    case (idx)
      3'd0:    sel_pat = snap[0];
      3'd1:    sel_pat = snap[1];
      3'd2:    sel_pat = snap[2];
      3'd3:    sel_pat = snap[3];
      3'd4:    sel_pat = snap[4];
      3'd5:    sel_pat = snap[5];
      default: sel_pat = 7'd0;
    endcase
    dec_in = SEG_ACTIVE_LOW ? ~sel_pat : sel_pat;
  end

  seg7_to_bcd u_dec (
    .pattern  (dec_in),
    .digit    (dec_digit),
    .is_blank (dec_blank),
    .is_err   (dec_err)
  );

  assign comb_s = bcd_field(digit_work[1], digit_work[0]);
  assign comb_m = bcd_field(digit_work[3], digit_work[2]);
  assign comb_h = bcd_field(digit_work[5], digit_work[4]);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = SCAN;
      SCAN:    if (idx == 3'd5) next_state = COMBINE;
      COMBINE: next_state = REPORT;
      REPORT:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        snap[i]       <= 7'd0;
        digit_work[i] <= 4'd0;
      end
      blank_work <= 6'd0;
      pat_work   <= 6'd0;
      idx        <= 3'd0;
      field_s    <= 7'd0;
      field_m    <= 7'd0;
      field_h    <= 7'd0;
      range_work <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      time_s     <= 6'd0;
      time_m     <= 6'd0;
      time_h     <= 6'd0;
      blank_mask <= 6'd0;
      pat_err    <= 6'd0;
      range_err  <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          snap[0] <= display_s1;
          snap[1] <= display_s2;
          snap[2] <= display_m1;
          snap[3] <= display_m2;
          snap[4] <= display_h1;
          snap[5] <= display_h2;
          for (int i = 0; i < 6; i++) digit_work[i] <= 4'd0;
          blank_work <= 6'd0;
          pat_work   <= 6'd0;
          range_work <= 3'd0;
          idx        <= 3'd0;
          busy       <= 1'b1;
        end
        SCAN: begin
          for (int i = 0; i < 6; i++) begin
            if (idx == 3'(i)) begin
              digit_work[i] <= dec_digit;
              blank_work[i] <= dec_blank;
              pat_work[i]   <= dec_err;
            end
          end
          idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
        COMBINE: begin
          field_s    <= comb_s;
          field_m    <= comb_m;
          field_h    <= comb_h;
          range_work <= {comb_h > 7'(HOUR_MAX), comb_m > FIELD_MAX, comb_s > FIELD_MAX};
        end
        REPORT: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          blank_mask <= blank_work;
          pat_err    <= pat_work;
          range_err  <= range_work;
          if (frame_ok) begin
            time_s <= field_s[5:0];
            time_m <= field_m[5:0];
            time_h <= field_h[5:0];
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEG7_DECODE_SEQ_CHECK_EN
  logic       prev_valid, in_seq;
  logic [5:0] succ_s, succ_m, succ_h;

  // time_* still holds the previous valid frame while REPORT is evaluated
  always_comb begin
    succ_s = time_s + 6'd1;
    succ_m = time_m;
    succ_h = time_h;
    if (time_s == 6'd59) begin
      succ_s = 6'd0;
      if (time_m == 6'd59) begin
        succ_m = 6'd0;
        succ_h = (time_h == 6'(HOUR_MAX)) ? 6'd0 : time_h + 6'd1;
      end else begin
        succ_m = time_m + 6'd1;
      end
    end
    in_seq = ({field_h[5:0], field_m[5:0], field_s[5:0]} == {time_h, time_m, time_s}) ||
             ({field_h[5:0], field_m[5:0], field_s[5:0]} == {succ_h, succ_m, succ_s});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
      seq_err    <= 1'b0;
    end else if (state == REPORT) begin
      if (frame_ok) begin
        prev_valid <= 1'b1;
        seq_err    <= prev_valid && (blank_work == 6'd0) && !in_seq;
      end else begin
        seq_err <= 1'b0;
      end
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule
